status_array_reader: RTL and testbench

// - Read port of the instruction-cache status array. The write side (init/fill) lives elsewhere.
// - Accepts lookup requests (row address + block select) and issues synchronous reads to the status SRAM.
// - Returns the full status row and the selected block's valid bit.
// - Merges a same-cycle fill update into the returned row, so lookups never return stale status.
// - Holds off all requests until status-array initialization completes.

---
 rtl/status_array_reader_pkg.sv | 27 ++
 rtl/status_array_reader_if.sv | 23 ++
 rtl/status_array_reader_row_merge.sv | 21 ++
 rtl/status_array_reader.sv | 104 ++++++++++
 tb/tb_status_array_reader.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/status_array_reader_pkg.sv
// Shared widths, FSM encoding and helpers for the instruction-cache status-array read port.
package status_array_reader_pkg;

   localparam int ADDR_WIDTH    = 6;
   localparam int ROW_WIDTH     = 8;
   localparam int NUM_BLOCKS    = 4;
   localparam int STAT_BITS     = ROW_WIDTH / NUM_BLOCKS;
   localparam int BLK_SEL_WIDTH = $clog2(NUM_BLOCKS);

   // Two-bit encoding leaves room for illegal codes, which the FSM folds back to WAIT_INIT.
   typedef enum logic [1:0] {
      ST_WAIT_INIT = 2'b00,
      ST_RUN       = 2'b01
   } state_t;

   // Valid flag (bit 0 of the block field) of the selected block within a status row.
   function automatic logic blk_valid_bit(input logic [ROW_WIDTH-1:0]     row,
                                          input logic [BLK_SEL_WIDTH-1:0] sel);
      logic v;
      v = 1'b0;
      for (int b = 0; b < NUM_BLOCKS; b++) begin
         if (sel == BLK_SEL_WIDTH'(b)) v = row[b*STAT_BITS];
      end
      return v;
   endfunction

endpackage

// File: rtl/status_array_reader_if.sv
// Lookup request/response bundle between the fetch pipeline (master) and the status reader (slave).
interface status_array_reader_if;
   import status_array_reader_pkg::*;

   logic                     i_valid;
   logic [ADDR_WIDTH-1:0]    i_addr;
   logic [BLK_SEL_WIDTH-1:0] i_blk_sel;
   logic                     o_ready;
   logic                     o_valid;
   logic [ROW_WIDTH-1:0]     o_status;
   logic                     o_blk_valid;

   modport master (
      output i_valid, i_addr, i_blk_sel,
      input  o_ready, o_valid, o_status, o_blk_valid
   );

   modport slave (
      input  i_valid, i_addr, i_blk_sel,
      output o_ready, o_valid, o_status, o_blk_valid
   );

endinterface

// File: rtl/status_array_reader_row_merge.sv
// Status-row merge: per block, take the fill-update field when it hit this read, else the SRAM field.
module status_array_reader_row_merge
   import status_array_reader_pkg::*;
(
   input  logic [ROW_WIDTH-1:0]  i_sram_row,
   input  logic                  i_upd_hit,
   input  logic [NUM_BLOCKS-1:0] i_upd_wmask,
   input  logic [ROW_WIDTH-1:0]  i_upd_row,
   output logic [ROW_WIDTH-1:0]  o_row
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_blk
         assign o_row[gi*STAT_BITS +: STAT_BITS] = (i_upd_hit & i_upd_wmask[gi])
                                                   ? i_upd_row[gi*STAT_BITS +: STAT_BITS]
                                                   : i_sram_row[gi*STAT_BITS +: STAT_BITS];
      end
   endgenerate

endmodule

// File: rtl/status_array_reader.sv
// Status-array read port: two-stage lookup pipeline (SRAM address, then merged response) behind
// an init gate; i_halt acts as a clock enable on every register, matching the halted SRAM.
module status_array_reader
   import status_array_reader_pkg::*;
(
   input  logic                   clk,
   input  logic                   arst_n,
   input  logic                   i_halt,
   input  logic                   i_init_done,
   status_array_reader_if.slave   lkp,
   output logic [ADDR_WIDTH-1:0]  o_sram_addr,
   output logic                   o_sram_ren,
   input  logic [ROW_WIDTH-1:0]   i_sram_data,
   input  logic                   i_upd_valid,
   input  logic [ADDR_WIDTH-1:0]  i_upd_addr,
   input  logic [NUM_BLOCKS-1:0]  i_upd_wmask,
   input  logic [ROW_WIDTH-1:0]   i_upd_data
);

   state_t                   r_state;
   state_t                   w_state_next;
   logic                     w_ready;
   logic                     w_accept;
   logic                     w_upd_hit;
   logic [ROW_WIDTH-1:0]     w_merged_row;

   logic                     r_sram_ren;
   logic [ADDR_WIDTH-1:0]    r_sram_addr;
   logic [BLK_SEL_WIDTH-1:0] r_s1_blk_sel;

   logic                     r_s2_valid;
   logic [BLK_SEL_WIDTH-1:0] r_s2_blk_sel;
   logic                     r_s2_upd_hit;
   logic [NUM_BLOCKS-1:0]    r_s2_upd_wmask;
   logic [ROW_WIDTH-1:0]     r_s2_upd_data;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state <= ST_WAIT_INIT;
      end else if (!i_halt) begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = ST_WAIT_INIT;
      w_ready      = 1'b0;
      case (r_state)
         ST_WAIT_INIT: w_state_next = i_init_done ? ST_RUN : ST_WAIT_INIT;
         ST_RUN: begin
            w_state_next = ST_RUN;
            w_ready      = ~i_halt;
         end
         default:      w_state_next = ST_WAIT_INIT;
      endcase
   end

   assign w_accept = lkp.i_valid & w_ready;

   // The SRAM returns pre-write data on a collision, so a fill hitting the row being read in
   // this cycle must be remembered and applied to the returned row next cycle.
   assign w_upd_hit = i_upd_valid & r_sram_ren & (i_upd_addr == r_sram_addr);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_sram_ren     <= 1'b0;
         r_sram_addr    <= '0;
         r_s1_blk_sel   <= '0;
         r_s2_valid     <= 1'b0;
         r_s2_blk_sel   <= '0;
         r_s2_upd_hit   <= 1'b0;
         r_s2_upd_wmask <= '0;
         r_s2_upd_data  <= '0;
      end else if (!i_halt) begin
         r_sram_ren <= w_accept;
         if (w_accept) begin
            r_sram_addr  <= lkp.i_addr;
            r_s1_blk_sel <= lkp.i_blk_sel;
         end
         r_s2_valid     <= r_sram_ren;
         r_s2_blk_sel   <= r_s1_blk_sel;
         r_s2_upd_hit   <= w_upd_hit;
         r_s2_upd_wmask <= i_upd_wmask;
         r_s2_upd_data  <= i_upd_data;
      end
   end

   status_array_reader_row_merge u_row_merge (
      .i_sram_row  (i_sram_data),
      .i_upd_hit   (r_s2_upd_hit),
      .i_upd_wmask (r_s2_upd_wmask),
      .i_upd_row   (r_s2_upd_data),
      .o_row       (w_merged_row)
   );

   // Response fields are forced to zero when no response is valid, so reset clears them at once.
   assign lkp.o_ready     = w_ready;
   assign lkp.o_valid     = r_s2_valid;
   assign lkp.o_status    = r_s2_valid ? w_merged_row : '0;
   assign lkp.o_blk_valid = r_s2_valid & blk_valid_bit(w_merged_row, r_s2_blk_sel);
   assign o_sram_ren      = r_sram_ren;
   assign o_sram_addr     = r_sram_addr;

endmodule

// File: tb/tb_status_array_reader.sv
// Directed plus random bench for status_array_reader against a request-queue reference model.
module tb_status_array_reader;
   import status_array_reader_pkg::*;

   logic       clk = 1'b0;
   logic       arst_n;
   logic       halt;
   logic       init_done;
   logic [5:0] sram_addr;
   logic       sram_ren;
   logic [7:0] sram_data;
   logic       upd_v;
   logic [5:0] upd_a;
   logic [3:0] upd_m;
   logic [7:0] upd_d;

   status_array_reader_if lkp();

   always #5 clk = ~clk;

   status_array_reader dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .i_halt      (halt),
      .i_init_done (init_done),
      .lkp         (lkp),
      .o_sram_addr (sram_addr),
      .o_sram_ren  (sram_ren),
      .i_sram_data (sram_data),
      .i_upd_valid (upd_v),
      .i_upd_addr  (upd_a),
      .i_upd_wmask (upd_m),
      .i_upd_data  (upd_d)
   );

   function automatic logic [7:0] apply_mask(input logic [7:0] row, input logic [3:0] m,
                                             input logic [7:0] d);
      logic [7:0] r;
      r = row;
      for (int k = 0; k < 4; k++) if (m[k]) r[2*k +: 2] = d[2*k +: 2];
      return r;
   endfunction

   // Synchronous-read SRAM, stalled by the same halt as the reader; reads return pre-write data.
   logic [7:0] sram_mem [64];
   always @(posedge clk) begin
      if (!halt) begin
         if (sram_ren) sram_data <= sram_mem[sram_addr];
         if (upd_v) sram_mem[upd_a] <= apply_mask(sram_mem[upd_a], upd_m, upd_d);
      end
   end

   // Reference model: accepted requests queue up; each resolves on the next unhalted edge
   // using memory contents before that edge's fill, plus that fill if it targets the same row.
   typedef struct {
      logic [5:0] addr;
      logic [1:0] blk;
      int         acc;
   } req_t;

   req_t       pend[$];
   logic [7:0] ref_mem [64];
   bit         m_run;
   int         ecnt;
   bit         e_out_v;
   logic [7:0] e_out_row;
   logic [1:0] e_out_blk;
   bit         e_ren;
   logic [5:0] e_saddr;
   int         n_checks;
   int         n_errors;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      m_run     = 1'b0;
      ecnt      = 0;
      e_out_v   = 1'b0;
      e_out_row = '0;
      e_out_blk = '0;
      e_ren     = 1'b0;
      e_saddr   = '0;
   endtask

   task automatic check_outputs(input bit h);
      chk("ready", lkp.o_ready, m_run & ~h);
      chk("sram_ren", sram_ren, e_ren);
      if (e_ren) chk("sram_addr", sram_addr, e_saddr);
      chk("valid", lkp.o_valid, e_out_v);
      chk("status", lkp.o_status, e_out_v ? e_out_row : 8'h00);
      chk("blk_valid", lkp.o_blk_valid, e_out_v ? e_out_row[e_out_blk*2] : 1'b0);
   endtask

   task automatic step(input bit v, input logic [5:0] a, input logic [1:0] b, input bit uv,
                       input logic [5:0] ua, input logic [3:0] um, input logic [7:0] ud,
                       input bit h);
      bit         acc;
      logic [7:0] row;
      lkp.i_valid   = v;
      lkp.i_addr    = a;
      lkp.i_blk_sel = b;
      upd_v = uv;
      upd_a = ua;
      upd_m = um;
      upd_d = ud;
      halt  = h;
      acc   = v && m_run && !h;
      @(posedge clk);
      if (!h) begin
         e_out_v   = 1'b0;
         e_out_row = '0;
         e_out_blk = '0;
         if (pend.size() > 0 && pend[0].acc == ecnt - 1) begin
            row = ref_mem[pend[0].addr];
            if (uv && ua == pend[0].addr) row = apply_mask(row, um, ud);
            e_out_v   = 1'b1;
            e_out_row = row;
            e_out_blk = pend[0].blk;
            void'(pend.pop_front());
         end
         if (uv) ref_mem[ua] = apply_mask(ref_mem[ua], um, ud);
         e_ren = acc;
         if (acc) begin
            e_saddr = a;
            pend.push_back('{a, b, ecnt});
         end
         if (init_done) m_run = 1'b1;
         ecnt++;
      end
      #1;
      check_outputs(h);
      if (lkp.o_valid)
         $display("t=%0t rsp status=%02h blk_valid=%0b", $time, lkp.o_status, lkp.o_blk_valid);
   endtask

   task automatic idle();
      step(1'b0, 6'd0, 2'd0, 1'b0, 6'd0, 4'h0, 8'h00, 1'b0);
   endtask

   initial begin
      logic [7:0] d;
      n_checks      = 0;
      n_errors      = 0;
      arst_n        = 1'b0;
      halt          = 1'b0;
      init_done     = 1'b0;
      lkp.i_valid   = 1'b0;
      lkp.i_addr    = '0;
      lkp.i_blk_sel = '0;
      upd_v = 1'b0;
      upd_a = '0;
      upd_m = '0;
      upd_d = '0;
      model_reset();
      #2;
      check_outputs(1'b0);
      #10;
      arst_n = 1'b1;

      // Held in WAIT_INIT with requests pending; preload the array through the fill port.
      for (int i = 0; i < 64; i++) begin
         d = 8'($urandom);
         if (i == 3) d = 8'hA5;
         if (i == 4) d = 8'h0F;
         if (i == 5) d = 8'hF0;
         if (i == 7) d = 8'h00;
         step(1'b1, 6'(i), 2'd0, 1'b1, 6'(i), 4'hF, d, 1'b0);
      end

      init_done = 1'b1;
      idle();

      // Back-to-back lookups, one response per cycle two cycles after accept.
      step(1'b1, 6'd3, 2'd0, 1'b0, 6'd0, 4'h0, 8'h00, 1'b0);
      step(1'b1, 6'd4, 2'd1, 1'b0, 6'd0, 4'h0, 8'h00, 1'b0);
      chk("row3", lkp.o_status, 8'hA5);
      step(1'b1, 6'd5, 2'd3, 1'b0, 6'd0, 4'h0, 8'h00, 1'b0);
      chk("row4", lkp.o_status, 8'h0F);
      idle();
      chk("row5", lkp.o_status, 8'hF0);
      idle();

      // Fill to the same row during the read's SRAM cycle is merged.
      step(1'b1, 6'd7, 2'd2, 1'b0, 6'd0, 4'h0, 8'h00, 1'b0);
      step(1'b0, 6'd0, 2'd0, 1'b1, 6'd7, 4'b0100, 8'h10, 1'b0);
      chk("merge_hit_status", lkp.o_status, 8'h10);
      chk("merge_hit_blk", lkp.o_blk_valid, 1'b1);
      step(1'b0, 6'd0, 2'd0, 1'b1, 6'd7, 4'hF, 8'h00, 1'b0);

      // Fill to a different row is not merged.
      step(1'b1, 6'd7, 2'd2, 1'b0, 6'd0, 4'h0, 8'h00, 1'b0);
      step(1'b0, 6'd0, 2'd0, 1'b1, 6'd8, 4'b0100, 8'h10, 1'b0);
      chk("merge_miss_status", lkp.o_status, 8'h00);
      chk("merge_miss_blk", lkp.o_blk_valid, 1'b0);
      idle();

      // Fill one cycle late: this read sees old data, a later read sees new data.
      step(1'b1, 6'd7, 2'd2, 1'b0, 6'd0, 4'h0, 8'h00, 1'b0);
      idle();
      chk("late_upd_old", lkp.o_status, 8'h00);
      step(1'b0, 6'd0, 2'd0, 1'b1, 6'd7, 4'hF, 8'h55, 1'b0);
      step(1'b1, 6'd7, 2'd2, 1'b0, 6'd0, 4'h0, 8'h00, 1'b0);
      idle();
      chk("late_upd_new", lkp.o_status, 8'h55);
      chk("late_upd_blk", lkp.o_blk_valid, 1'b1);
      idle();

      // Halt with two requests in flight.
      step(1'b1, 6'd10, 2'd1, 1'b0, 6'd0, 4'h0, 8'h00, 1'b0);
      step(1'b1, 6'd11, 2'd3, 1'b0, 6'd0, 4'h0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 6'd12, 2'd0, 1'b0, 6'd0, 4'h0, 8'h00, 1'b1);
      idle();
      chk("halt_second_rsp", lkp.o_status, ref_mem[11]);
      idle();

      // Random traffic over a few rows to provoke collisions, stalls and init_done toggling.
      for (int i = 0; i < 300; i++) begin
         init_done = 1'($urandom_range(0, 1));
         step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)), 4'($urandom),
              8'($urandom), $urandom_range(0, 7) == 0);
      end
      init_done = 1'b1;
      idle();
      idle();

      // Asynchronous reset with a response showing.
      step(1'b1, 6'd20, 2'd1, 1'b0, 6'd0, 4'h0, 8'h00, 1'b0);
      idle();
      chk("pre_reset_valid", lkp.o_valid, 1'b1);
      #3;
      arst_n = 1'b0;
      #1;
      chk("rst_valid", lkp.o_valid, 1'b0);
      chk("rst_status", lkp.o_status, 8'h00);
      chk("rst_ready", lkp.o_ready, 1'b0);
      chk("rst_sram_ren", sram_ren, 1'b0);
      model_reset();
      init_done = 1'b0;
      #3;
      arst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 6'd21, 2'd0, 1'b0, 6'd0, 4'h0, 8'h00, 1'b0);
      init_done = 1'b1;
      idle();
      step(1'b1, 6'd20, 2'd1, 1'b0, 6'd0, 4'h0, 8'h00, 1'b0);
      idle();
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
